// File: rtl/codec_cfg_sequencer_if.sv
// Command/transfer handshake to the byte-level I2C write engine plus the
// runtime host write port. The sequencer is the master.
interface codec_cfg_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_word;
  logic        xfer_done;
  logic        xfer_nack;
  logic        host_req_valid;
  logic        host_req_ready;
  logic [6:0]  host_req_addr;
  logic [8:0]  host_req_data;

  modport master (
    output cmd_valid, cmd_word, host_req_ready,
    input  cmd_ready, xfer_done, xfer_nack,
    input  host_req_valid, host_req_addr, host_req_data
  );

  modport slave (
    input  cmd_valid, cmd_word, host_req_ready,
    output cmd_ready, xfer_done, xfer_nack,
    output host_req_valid, host_req_addr, host_req_data
  );
endinterface

// File: rtl/codec_cfg_sequencer.sv
// WM8731 configuration sequencer: plays the power-up register table through
// the I2C write engine, then serves single host writes. One write in flight,
// NACKed writes are re-issued up to RETRY_MAX times before a sticky error.
module codec_cfg_sequencer #(
  parameter logic [7:0] DEV_ADDR      = 8'h34,
  parameter int         NUM_BOOT      = 9,
  parameter int         RETRY_MAX     = 3,
  parameter int         SETTLE_CYCLES = 7372800
) (
  input  logic         clk,
  input  logic         rst,
  codec_cfg_if.master  bus,
  output logic         cfg_done,
  output logic         cfg_error,
  output logic         speaker_mute
);

  typedef enum logic [2:0] {
    BOOT_ISSUE, BOOT_WAIT, SETTLE, RUN, HOST_ISSUE, HOST_WAIT, ERROR
  } state_e;

  localparam logic [3:0]  LAST_IDX    = 4'(NUM_BOOT - 1);
  localparam logic [1:0]  RETRY_LIM   = 2'(RETRY_MAX);
  localparam logic [22:0] SETTLE_LAST = 23'(SETTLE_CYCLES - 1);

  // Power-up table as {reg[6:0], data[8:0]}; the second 06 entry clears
  // OUTPD and must only go out after the output stage has settled.
  function automatic logic [15:0] boot_entry(input logic [3:0] i);
    logic [15:0] e;
    e = 16'h0000;
    case (i)
      4'd0: e = {7'h0F, 9'h000};
      4'd1: e = {7'h06, 9'h070};
      4'd2: e = {7'h04, 9'h015};
      4'd3: e = {7'h01, 9'h117};
      4'd4: e = {7'h05, 9'h000};
      4'd5: e = {7'h07, 9'h009};
      4'd6: e = {7'h02, 9'h1E5};
      4'd7: e = {7'h09, 9'h001};
      4'd8: e = {7'h06, 9'h060};
      default: e = 16'h0000;
    endcase
    return e;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [1:0]  retry_q, retry_d;
  logic [22:0] settle_q, settle_d;
  logic [6:0]  haddr_q, haddr_d;
  logic [8:0]  hdata_q, hdata_d;

  logic        cmd_valid_q, cmd_valid_d;
  logic [23:0] cmd_word_q, cmd_word_d;
  logic        host_rdy_q, host_rdy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        mute_q, mute_d;

  logic cmd_hs, host_hs;

  assign cmd_hs  = cmd_valid_q & bus.cmd_ready;
  assign host_hs = bus.host_req_valid & host_rdy_q;

  assign bus.cmd_valid      = cmd_valid_q;
  assign bus.cmd_word       = cmd_word_q;
  assign bus.host_req_ready = host_rdy_q;
  assign cfg_done           = done_q;
  assign cfg_error          = err_q;
  assign speaker_mute       = mute_q;

  // State and registered outputs; reset restarts the boot table from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BOOT_ISSUE;
      idx_q       <= '0;
      retry_q     <= '0;
      settle_q    <= '0;
      haddr_q     <= '0;
      hdata_q     <= '0;
      cmd_valid_q <= 1'b0;
      cmd_word_q  <= '0;
      host_rdy_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mute_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      settle_q    <= settle_d;
      haddr_q     <= haddr_d;
      hdata_q     <= hdata_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_word_q  <= cmd_word_d;
      host_rdy_q  <= host_rdy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mute_q      <= mute_d;
    end
  end

  // Next-state: sequencing, retry accounting, settle timer, host latch.
  // xfer_done is only looked at in the two WAIT states, so stray pulses
  // (e.g. from a transfer cut off by reset) fall through harmlessly.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    retry_d  = retry_q;
    settle_d = settle_q;
    haddr_d  = haddr_q;
    hdata_d  = hdata_q;
    unique case (state_q)
      BOOT_ISSUE: if (cmd_hs) state_d = BOOT_WAIT;
      BOOT_WAIT: begin
        if (bus.xfer_done) begin
          if (bus.xfer_nack) begin
            if (retry_q == RETRY_LIM) begin
              state_d = ERROR;
            end else begin
              retry_d = retry_q + 2'd1;
              state_d = BOOT_ISSUE;
            end
          end else begin
            retry_d = '0;
            idx_d   = idx_q + 4'd1;
            if (idx_q == LAST_IDX) begin
              state_d = RUN;
            end else if (idx_q + 4'd1 == LAST_IDX) begin
              settle_d = '0;
              state_d  = SETTLE;
            end else begin
              state_d = BOOT_ISSUE;
            end
          end
        end
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = BOOT_ISSUE;
        else                         settle_d = settle_q + 23'd1;
      end
      RUN: begin
        if (host_hs) begin
          haddr_d = bus.host_req_addr;
          hdata_d = bus.host_req_data;
          retry_d = '0;
          state_d = HOST_ISSUE;
        end
      end
      HOST_ISSUE: if (cmd_hs) state_d = HOST_WAIT;
      HOST_WAIT: begin
        if (bus.xfer_done) begin
          if (bus.xfer_nack) begin
            if (retry_q == RETRY_LIM) begin
              state_d = ERROR;
            end else begin
              retry_d = retry_q + 2'd1;
              state_d = HOST_ISSUE;
            end
          end else begin
            state_d = RUN;
          end
        end
      end
      ERROR: state_d = ERROR;
      default: state_d = BOOT_ISSUE;
    endcase
  end

  // Outputs decoded from the next state so they are registered yet line up
  // with the state they belong to; cmd_word holds between issues.
  always_comb begin
    cmd_valid_d = (state_d == BOOT_ISSUE) || (state_d == HOST_ISSUE);
    cmd_word_d  = cmd_word_q;
    if (state_d == BOOT_ISSUE)      cmd_word_d = {DEV_ADDR, boot_entry(idx_d)};
    else if (state_d == HOST_ISSUE) cmd_word_d = {DEV_ADDR, haddr_d, hdata_d};
    host_rdy_d = (state_d == RUN);
    done_d     = done_q | (state_d == RUN);
    err_d      = err_q | (state_d == ERROR);
    mute_d     = ~done_d;
  end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
module tb_codec_cfg_sequencer;
  localparam int SETTLE   = 16;
  localparam int DONE_LAT = 3;
  localparam int RMAX     = 3;
  localparam logic [23:0] W_LAST = 24'h340C60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_done, cfg_error, speaker_mute;

  codec_cfg_if bus();

  codec_cfg_sequencer #(
    .DEV_ADDR(8'h34), .NUM_BOOT(9), .RETRY_MAX(RMAX), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cfg_done(cfg_done), .cfg_error(cfg_error), .speaker_mute(speaker_mute)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expected command words, and the engine's ack/nack script.
  logic [23:0] exp_q[$];
  bit          nack_q[$];

  int boot_reg[9] = '{'h0F, 'h06, 'h04, 'h01, 'h05, 'h07, 'h02, 'h09, 'h06};
  int boot_dat[9] = '{'h000, 'h070, 'h015, 'h117, 'h000, 'h009, 'h1E5, 'h001, 'h060};
  int plan_nk[9];

  bit          rand_ready = 0;
  logic [23:0] stall_word = '0;
  int          stall_len = 0;
  int          stall_cnt = 0;
  int          stray_req = 0;
  int          stray_ack = 0;

  function automatic logic [23:0] word_of(input int r, input int d);
    return 24'(32'h340000 + r * 512 + d);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // Reference model: each boot entry is issued once plus once per NACK,
  // capped at RETRY_MAX re-issues; an exhausted entry ends the sequence.
  task automatic plan_boot();
    for (int e = 0; e < 9; e++) begin
      int n;
      int att;
      n   = plan_nk[e];
      att = (n > RMAX) ? RMAX + 1 : n + 1;
      for (int a = 0; a < att; a++) begin
        exp_q.push_back(word_of(boot_reg[e], boot_dat[e]));
        nack_q.push_back(a < n);
      end
      if (n > RMAX) break;
    end
  endtask

  // I2C engine model: accepts per ready policy, answers DONE_LAT cycles later.
  bit lv = 0, lr = 0, pend = 0, pnack = 0;
  int ecnt = 0;
  always @(posedge clk) begin
    #1;
    bus.xfer_done = 1'b0;
    bus.xfer_nack = 1'b0;
    if (rst) begin
      pend = 0; lv = 0; lr = 0;
      bus.cmd_ready = 1'b0;
      if (stray_ack != stray_req) begin
        bus.xfer_done = 1'b1;
        stray_ack++;
      end
    end else begin
      if (pend) begin
        ecnt--;
        if (ecnt == 0) begin
          bus.xfer_done = 1'b1;
          bus.xfer_nack = pnack;
          pend = 0;
        end
      end
      if (lv && lr) begin
        pend  = 1;
        ecnt  = DONE_LAT - 1;
        pnack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
      end
      if (bus.cmd_valid && bus.cmd_word == stall_word && stall_cnt < stall_len) begin
        bus.cmd_ready = 1'b0;
        stall_cnt++;
      end else begin
        bus.cmd_ready = rand_ready ? ($urandom_range(0, 99) < 60) : 1'b1;
      end
      lv = bus.cmd_valid;
      lr = bus.cmd_ready;
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks hold/stability
  // and issue timing relative to the preceding done.
  bit          pv = 0, pr = 0, done_since = 0;
  logic [23:0] pw = '0;
  int          done_cyc = 0;
  int          stall_seen = 0;
  int          issued = 0;
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      pv = 0; pr = 0; done_since = 0;
    end else begin
      if (pv && !pr) begin
        chk("valid_held", bus.cmd_valid, 1);
        chk("word_stable", bus.cmd_word, pw);
      end
      if (bus.cmd_valid && !pv) begin
        // a settle window of SETTLE cycles sits between the 8th done and the last issue
        if (!cfg_done && done_since)
          chk("issue_gap", cyc - done_cyc, (bus.cmd_word == W_LAST) ? SETTLE + 1 : 1);
        done_since = 0;
      end
      if (bus.xfer_done) begin
        done_since = 1;
        done_cyc   = cyc;
      end
      if (bus.cmd_valid) chk("host_rdy_while_issue", bus.host_req_ready, 0);
      if (bus.cmd_valid && bus.cmd_ready) begin
        issued++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd act=%0h req=none", bus.cmd_word);
        end else begin
          chk("cmd_word", bus.cmd_word, exp_q.pop_front());
        end
      end
      if (bus.cmd_valid && !bus.cmd_ready && bus.cmd_word == stall_word) stall_seen++;
      pv = bus.cmd_valid;
      pr = bus.cmd_ready;
      pw = bus.cmd_word;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    nack_q.delete();
    step(3);
  endtask

  task automatic release_rst();
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic wait_cfg(input string tag);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (cfg_done || cfg_error) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout act=none req=cfg_done_or_error", tag);
  endtask

  task automatic clear_plan();
    for (int e = 0; e < 9; e++) plan_nk[e] = 0;
  endtask

  task automatic boot_ok(input string tag);
    release_rst();
    @(negedge clk);
    chk({tag, "_mute_early"}, speaker_mute, 1);
    wait_cfg(tag);
    chk({tag, "_done"}, cfg_done, 1);
    chk({tag, "_done_timing"}, cyc - done_cyc, 1);
    chk({tag, "_mute"}, speaker_mute, 0);
    chk({tag, "_err"}, cfg_error, 0);
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic host_write(input int addr, input int data, input int nk);
    bit got, ack_prev;
    step(1);
    for (int a = 0; a <= nk; a++) begin
      exp_q.push_back(word_of(addr, data));
      nack_q.push_back(a < nk);
    end
    bus.host_req_addr  = 7'(addr);
    bus.host_req_data  = 9'(data);
    bus.host_req_valid = 1'b1;
    got = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.host_req_ready) begin got = 1; break; end
    end
    chk("host_accept", got, 1);
    step(1);
    bus.host_req_valid = 1'b0;
    bus.host_req_addr  = 7'($urandom);
    bus.host_req_data  = 9'($urandom);
    got = 0;
    ack_prev = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (bus.host_req_ready) begin got = 1; break; end
      ack_prev = bus.xfer_done && !bus.xfer_nack;
    end
    chk("host_ready_return", got, 1);
    chk("host_ready_after_ack", ack_prev, 1);
    chk("host_drained", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int base;
    bus.host_req_valid = 1'b0;
    bus.host_req_addr  = '0;
    bus.host_req_data  = '0;

    // reset values
    do_reset();
    @(negedge clk);
    chk("rst_cmd_valid", bus.cmd_valid, 0);
    chk("rst_cmd_word", bus.cmd_word, 0);
    chk("rst_host_rdy", bus.host_req_ready, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_err", cfg_error, 0);
    chk("rst_mute", speaker_mute, 1);

    // clean boot, then host write 02:1FF
    clear_plan();
    plan_boot();
    base = issued;
    boot_ok("clean");
    chk("clean_count", issued - base, 9);
    host_write(2, 'h1FF, 0);

    // engine stalls entry 2 for 20 cycles
    do_reset();
    clear_plan();
    plan_boot();
    stall_word = 24'h340815;
    stall_len  = stall_cnt + 20;
    base       = stall_seen;
    boot_ok("stall");
    chk("stall_cycles", stall_seen - base, 20);
    stall_word = '0;

    // two NACKs on entry 1
    do_reset();
    clear_plan();
    plan_nk[1] = 2;
    plan_boot();
    base = issued;
    boot_ok("nack2");
    chk("nack2_count", issued - base, 11);

    // entry 4 NACKed four times -> error
    do_reset();
    clear_plan();
    plan_nk[4] = 4;
    plan_boot();
    release_rst();
    wait_cfg("exhaust");
    chk("exhaust_err", cfg_error, 1);
    chk("exhaust_done", cfg_done, 0);
    bus.host_req_valid = 1'b1;
    step(30);
    @(negedge clk);
    chk("exhaust_valid", bus.cmd_valid, 0);
    chk("exhaust_host_rdy", bus.host_req_ready, 0);
    chk("exhaust_mute", speaker_mute, 1);
    chk("exhaust_drained", exp_q.size(), 0);
    bus.host_req_valid = 1'b0;

    // reset while entry 5 awaits done, stray done during reset
    do_reset();
    clear_plan();
    plan_boot();
    release_rst();
    found = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (bus.cmd_valid && bus.cmd_ready && bus.cmd_word == 24'h340E09) begin found = 1; break; end
    end
    chk("entry5_reached", found, 1);
    step(1);
    rst = 1'b1;
    stray_req++;
    exp_q.delete();
    nack_q.delete();
    step(3);
    @(negedge clk);
    chk("abort_valid", bus.cmd_valid, 0);
    chk("abort_done", cfg_done, 0);
    chk("abort_mute", speaker_mute, 1);
    plan_boot();
    release_rst();
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.cmd_valid) begin found = 1; break; end
    end
    chk("restart_issued", found, 1);
    chk("restart_word", bus.cmd_word, 24'h341E00);
    chk("restart_mute", speaker_mute, 1);
    wait_cfg("restart");
    chk("restart_done", cfg_done, 1);
    chk("restart_drained", exp_q.size(), 0);

    // randomized rounds: random ready, random recoverable NACKs, host writes
    rand_ready = 1;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int e = 0; e < 9; e++)
        plan_nk[e] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      plan_boot();
      boot_ok("rand");
      for (int h = 0; h < 3; h++)
        host_write($urandom_range(0, 127), $urandom_range(0, 511), $urandom_range(0, 2));
    end
    rand_ready = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
